// File: rtl/reg_load_sched_pkg.sv
// Shared types and constants for the register load scheduler.
package reg_load_sched_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } state_e;

   // Small prescaler divide used by simulation benches instead of 50 MHz -> 1 Hz.
   localparam int SIM_TICK_DIV = 4;

   // Owner index is sized for the largest supported requester count.
   localparam int MAX_REQ = 8;
   localparam int OWNER_W = $clog2(MAX_REQ);

endpackage

// File: rtl/reg_load_sched_tick_gen.sv
// Prescaler: a one-cycle clock-enable pulse every TICK_DIV clk cycles.
module reg_load_sched_tick_gen
   import reg_load_sched_pkg::*;
#(
   parameter int TICK_DIV = SIM_TICK_DIV
) (
   input  logic clk,
   input  logic clr_n,
   output logic tick
);

   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tick_q, tick_d;

   // Wrap the count at TICK_DIV-1; tick follows the terminal count by one cycle.
   always_comb begin
      cnt_d  = cnt_q + 1'b1;
      tick_d = 1'b0;
      if (cnt_q == LAST) begin
         cnt_d  = '0;
         tick_d = 1'b1;
      end
   end

   // Prescaler state.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
      end
   end

   assign tick = tick_q;

endmodule

// File: rtl/reg_load_sched.sv
// Tick-paced round-robin loader for a shared W-bit holding register.
module reg_load_sched
   import reg_load_sched_pkg::*;
#(
   parameter int W          = 4,
   parameter int N_REQ      = 4,
   parameter int TICK_DIV   = 50000000,
   parameter int HOLD_TICKS = 1
) (
   input  logic                 clk,
   input  logic                 clr_n,
   input  logic [N_REQ-1:0]     req,
   input  logic [N_REQ*W-1:0]   data,
   input  logic                 clr_q,
   output logic [W-1:0]         q,
   output logic [N_REQ-1:0]     gnt,
   output logic [OWNER_W-1:0]   owner,
   output logic                 busy,
   output logic                 tick
);

   state_e               state_q, state_d;
   logic [W-1:0]         q_q, q_d;
   logic [N_REQ-1:0]     gnt_q, gnt_d;
   logic [OWNER_W-1:0]   owner_q, owner_d;
   logic [N_REQ-1:0]     served_q, served_d;
   logic                 pend_q, pend_d;
   logic [3:0]           hcnt_q, hcnt_d;

   logic [N_REQ-1:0]     elig;
   logic [OWNER_W-1:0]   pick;
   logic [N_REQ-1:0]     onehot;
   logic [3:0]           hcnt_inc;
   logic                 clr_now;

   // First eligible index strictly after 'last', wrapping to 0.
   function automatic logic [OWNER_W-1:0] rr_pick(input logic [N_REQ-1:0] e,
                                                  input logic [OWNER_W-1:0] last);
      logic [OWNER_W-1:0] res;
      logic [N_REQ-1:0]   hit;
      logic               found;
      int                 idx;
      res   = last;
      found = 1'b0;
      for (int k = 1; k <= N_REQ; k++) begin
         idx = (int'(last) + k) % N_REQ;
         hit = e >> idx;
         if (!found && hit[0]) begin
            res   = OWNER_W'(idx);
            found = 1'b1;
         end
      end
      return res;
   endfunction

   reg_load_sched_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk   (clk),
      .clr_n (clr_n),
      .tick  (tick)
   );

   // Next-state: served/clear bookkeeping every cycle, decisions only on the tick edge.
   always_comb begin
      clr_now  = pend_q | clr_q;
      elig     = req & ~served_q;
      pick     = rr_pick(elig, owner_q);
      onehot   = N_REQ'(1) << pick;
      hcnt_inc = hcnt_q + 4'd1;

      state_d  = state_q;
      q_d      = q_q;
      gnt_d    = '0;
      owner_d  = owner_q;
      served_d = served_q & req;
      pend_d   = clr_now;
      hcnt_d   = hcnt_q;

      if (tick) begin
         if (clr_now) begin
            // A clear beats both a new load and an in-progress hold.
            q_d     = '0;
            pend_d  = 1'b0;
            hcnt_d  = '0;
            state_d = ST_IDLE;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (|elig) begin
                     q_d      = W'(data >> (int'(pick) * W));
                     gnt_d    = onehot;
                     owner_d  = pick;
                     served_d = served_d | onehot;
                     state_d  = (HOLD_TICKS > 0) ? ST_HOLD : ST_IDLE;
                  end
               end
               ST_HOLD: begin
                  if (hcnt_inc == 4'(HOLD_TICKS)) begin
                     hcnt_d  = '0;
                     state_d = ST_IDLE;
                  end else begin
                     hcnt_d  = hcnt_inc;
                  end
               end
               default: state_d = ST_IDLE;
            endcase
         end
      end
   end

   // Scheduler state registers.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_q  <= ST_IDLE;
         q_q      <= '0;
         gnt_q    <= '0;
         owner_q  <= OWNER_W'(N_REQ - 1);
         served_q <= '0;
         pend_q   <= 1'b0;
         hcnt_q   <= '0;
      end else begin
         state_q  <= state_d;
         q_q      <= q_d;
         gnt_q    <= gnt_d;
         owner_q  <= owner_d;
         served_q <= served_d;
         pend_q   <= pend_d;
         hcnt_q   <= hcnt_d;
      end
   end

   assign q     = q_q;
   assign gnt   = gnt_q;
   assign owner = owner_q;
   assign busy  = (state_q == ST_HOLD);

endmodule

// File: tb/tb_reg_load_sched.sv
// Scoreboard bench for reg_load_sched: stimulus pushes per-tick expectations,
// a negedge monitor checks every cycle against the most recent expectation.
module tb_reg_load_sched;
   import reg_load_sched_pkg::*;

   localparam int TD = SIM_TICK_DIV;

   logic        clk   = 1'b0;
   logic        clr_n = 1'b0;
   logic [3:0]  req   = '0;
   logic [15:0] data  = '0;
   logic        clr_q = 1'b0;
   logic [3:0]  q;
   logic [3:0]  gnt;
   logic [2:0]  owner;
   logic        busy;
   logic        tick;

   always #5 clk = ~clk;

   reg_load_sched #(.W(4), .N_REQ(4), .TICK_DIV(TD), .HOLD_TICKS(1)) dut (
      .clk   (clk),
      .clr_n (clr_n),
      .req   (req),
      .data  (data),
      .clr_q (clr_q),
      .q     (q),
      .gnt   (gnt),
      .owner (owner),
      .busy  (busy),
      .tick  (tick)
   );

   typedef struct {
      logic [3:0] gnt;
      logic [3:0] q;
      logic [2:0] owner;
      logic       busy;
      int         id;
   } exp_t;

   exp_t sb[$];
   exp_t cur;
   int   total   = 0;
   int   bad     = 0;
   int   step_id = 0;

   // Reference prescaler: tick follows count==TD-1; res marks the cycle after a tick.
   int   tcnt   = 0;
   logic tick_m = 1'b0;
   logic res_m  = 1'b0;

   always @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         tcnt   <= 0;
         tick_m <= 1'b0;
         res_m  <= 1'b0;
      end else begin
         tick_m <= (tcnt == TD - 1);
         tcnt   <= (tcnt == TD - 1) ? 0 : tcnt + 1;
         res_m  <= tick_m;
      end
   end

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Monitor: pops an expectation in each post-tick cycle, holds it otherwise.
   always @(negedge clk) begin
      if (!clr_n) begin
         cur = '{gnt: 4'h0, q: 4'h0, owner: 3'd3, busy: 1'b0, id: -1};
      end else begin
         chk("tick", 16'(tick), 16'(tick_m));
         if (res_m) begin
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_result actual=none required=queued");
            end else begin
               cur = sb.pop_front();
            end
            chk($sformatf("gnt#%0d", cur.id), 16'(gnt), 16'(cur.gnt));
         end else begin
            chk($sformatf("gnt_idle#%0d", cur.id), 16'(gnt), 16'h0);
         end
         chk($sformatf("q#%0d", cur.id), 16'(q), 16'(cur.q));
         chk($sformatf("owner#%0d", cur.id), 16'(owner), 16'(cur.owner));
         chk($sformatf("busy#%0d", cur.id), 16'(busy), 16'(cur.busy));
      end
   end

   // One tick: drive inputs in the tick cycle, queue the expected outcome,
   // then optionally drop granted reqs and/or pulse clr_q while holding.
   task automatic tstep(input logic [3:0] r, input logic c, input logic [3:0] drop,
                        input logic cmid, input logic [3:0] eg, input logic [3:0] eq,
                        input logic [2:0] eo, input logic eb);
      exp_t e;
      int   guard;
      guard = 0;
      do begin
         @(negedge clk);
         guard++;
      end while (tick_m !== 1'b1 && guard < 4 * TD);
      if (guard >= 4 * TD) begin
         total++;
         bad++;
         $display("FAIL tick_wait actual=timeout required=tick");
      end
      req   = r;
      clr_q = c;
      e.gnt = eg; e.q = eq; e.owner = eo; e.busy = eb; e.id = step_id;
      step_id++;
      sb.push_back(e);
      @(negedge clk);
      clr_q = 1'b0;
      req   = req & ~drop;
      if (cmid) begin
         @(negedge clk);
         clr_q = 1'b1;
         @(negedge clk);
         clr_q = 1'b0;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      data = {4'h4, 4'hA, 4'h7, 4'h3};
      repeat (3) @(negedge clk);
      chk("rst_q", 16'(q), 16'h0);
      chk("rst_gnt", 16'(gnt), 16'h0);
      chk("rst_owner", 16'(owner), 16'h3);
      chk("rst_busy", 16'(busy), 16'h0);
      chk("rst_tick", 16'(tick), 16'h0);
      clr_n = 1'b1;

      // Idle ticks after reset.
      repeat (3) tstep(4'b0000, 0, 4'b0000, 0, 4'b0000, 4'h0, 3'd3, 0);

      // All four requesting; each drops after its grant.
      tstep(4'b1111, 0, 4'b0001, 0, 4'b0001, 4'h3, 3'd0, 1);
      tstep(4'b1111, 0, 4'b0000, 0, 4'b0000, 4'h3, 3'd0, 0);
      tstep(4'b1111, 0, 4'b0010, 0, 4'b0010, 4'h7, 3'd1, 1);
      tstep(4'b1111, 0, 4'b0000, 0, 4'b0000, 4'h7, 3'd1, 0);
      tstep(4'b1111, 0, 4'b0100, 0, 4'b0100, 4'hA, 3'd2, 1);
      tstep(4'b1111, 0, 4'b0000, 0, 4'b0000, 4'hA, 3'd2, 0);
      tstep(4'b1111, 0, 4'b1000, 0, 4'b1000, 4'h4, 3'd3, 1);
      tstep(4'b1111, 0, 4'b0000, 0, 4'b0000, 4'h4, 3'd3, 0);
      tstep(4'b1111, 0, 4'b0001, 0, 4'b0001, 4'h3, 3'd0, 1);
      tstep(4'b0000, 0, 4'b0000, 0, 4'b0000, 4'h3, 3'd0, 0);

      // Single request from requester 2.
      tstep(4'b0100, 0, 4'b0100, 0, 4'b0100, 4'hA, 3'd2, 1);
      tstep(4'b0000, 0, 4'b0000, 0, 4'b0000, 4'hA, 3'd2, 0);

      // Requester 1 keeps req high: served once, then locked out until it drops.
      tstep(4'b0010, 0, 4'b0000, 0, 4'b0010, 4'h7, 3'd1, 1);
      tstep(4'b0010, 0, 4'b0000, 0, 4'b0000, 4'h7, 3'd1, 0);
      tstep(4'b0010, 0, 4'b0000, 0, 4'b0000, 4'h7, 3'd1, 0);
      tstep(4'b1010, 0, 4'b1000, 0, 4'b1000, 4'h4, 3'd3, 1);
      tstep(4'b0010, 0, 4'b0000, 0, 4'b0000, 4'h4, 3'd3, 0);
      tstep(4'b0010, 0, 4'b0010, 0, 4'b0000, 4'h4, 3'd3, 0);
      tstep(4'b0010, 0, 4'b0010, 0, 4'b0010, 4'h7, 3'd1, 1);
      tstep(4'b0000, 0, 4'b0000, 0, 4'b0000, 4'h7, 3'd1, 0);

      // Clear pulse during HOLD after loading 5.
      data[3:0] = 4'h5;
      tstep(4'b0001, 0, 4'b0001, 1, 4'b0001, 4'h5, 3'd0, 1);
      tstep(4'b0100, 0, 4'b0000, 0, 4'b0000, 4'h0, 3'd0, 0);
      tstep(4'b0100, 0, 4'b0100, 0, 4'b0100, 4'hA, 3'd2, 1);
      tstep(4'b0000, 0, 4'b0000, 0, 4'b0000, 4'hA, 3'd2, 0);

      // Clear on the tick edge itself with req[0] pending.
      tstep(4'b0001, 1, 4'b0000, 0, 4'b0000, 4'h0, 3'd2, 0);
      tstep(4'b0001, 0, 4'b0001, 0, 4'b0001, 4'h5, 3'd0, 1);

      // Asynchronous reset while holding.
      @(negedge clk);
      #2 clr_n = 1'b0;
      #1;
      chk("arst_q", 16'(q), 16'h0);
      chk("arst_gnt", 16'(gnt), 16'h0);
      chk("arst_owner", 16'(owner), 16'h3);
      chk("arst_busy", 16'(busy), 16'h0);
      chk("arst_tick", 16'(tick), 16'h0);
      req = '0;
      repeat (2) @(negedge clk);
      clr_n = 1'b1;
      repeat (TD - 1) @(posedge clk);
      #1 chk("arst_tick_early", 16'(tick), 16'h0);
      @(posedge clk);
      #1 chk("arst_tick_first", 16'(tick), 16'h1);
      tstep(4'b0000, 0, 4'b0000, 0, 4'b0000, 4'h0, 3'd3, 0);
      tstep(4'b0001, 0, 4'b0001, 0, 4'b0001, 4'h5, 3'd0, 1);
      tstep(4'b0000, 0, 4'b0000, 0, 4'b0000, 4'h5, 3'd0, 0);

      repeat (2) @(negedge clk);
      chk("sb_empty", 16'(sb.size()), 16'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
